// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file for the decode/writeback pipeline.
// There are NUM_RD combinational read ports and two write ports. On a
// same-address collision, write port 1 wins. Bypass from write to read is
// optional. A sequential soft-clear engine wipes every entry without reset.
//
// state  | meaning
// IDLE   | normal operation: writes commit and bypass is active
// CLEAR  | one entry is zeroed per cycle; writes are dropped and bypass is off
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
    output logic [NUM_RD*DATA_W-1:0]   rdData,
    input  logic                       wrEn0,
    input  logic [ADDR_W-1:0]          wrAddr0,
    input  logic [DATA_W-1:0]          wrData0,
    input  logic                       wrEn1,
    input  logic [ADDR_W-1:0]          wrAddr1,
    input  logic [DATA_W-1:0]          wrData1,
    input  logic                       clrReq,
    output logic                       busy,
    output logic                       wrDropped
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_drop;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_idle;
    logic w_wr0_ok;
    logic w_wr1_ok;

    assign w_idle = (r_state == ST_IDLE);

    // Port 0 loses to port 1 on the same address, so its write is suppressed outright.
    assign w_wr0_ok = w_idle && wrEn0
                      && !((ZERO_REG != 0) && (wrAddr0 == '0))
                      && !(wrEn1 && (wrAddr1 == wrAddr0));
    assign w_wr1_ok = w_idle && wrEn1
                      && !((ZERO_REG != 0) && (wrAddr1 == '0));

    assign busy      = (r_state == ST_CLEAR);
    assign wrDropped = r_drop;

    // Clear sequencer: walks r_cnt over every entry, then returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clrReq) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Registered pulse flags any write attempt that was discarded during a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= (r_state == ST_CLEAR) && (wrEn0 || wrEn1);
        end
    end

    // Storage: reset zeroes everything, a clear zeroes one entry per cycle, IDLE commits writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else begin
            if (w_wr0_ok) begin
                r_mem[wrAddr0] <= wrData0;
            end
            if (w_wr1_ok) begin
                r_mem[wrAddr1] <= wrData1;
            end
        end
    end

    // Read ports: array value, overridden by the IDLE-only bypass, then by the zero register.
    always_comb begin
        rdData = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_val;
            w_ra  = rdAddr[k*ADDR_W +: ADDR_W];
            w_val = r_mem[w_ra];
            if ((BYPASS != 0) && w_idle) begin
                if (wrEn1 && (wrAddr1 == w_ra)) begin
                    w_val = wrData1;
                end else if (wrEn0 && (wrAddr0 == w_ra)) begin
                    w_val = wrData0;
                end
            end
            if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_val = '0;
            end
            rdData[k*DATA_W +: DATA_W] = w_val;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. It drives two instances from the same
// stimulus: one with bypass and one without.
module tb_reg_file_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rdAddr;
    logic        wrEn0, wrEn1, clrReq;
    logic [4:0]  wrAddr0, wrAddr1;
    logic [31:0] wrData0, wrData1;
    logic [63:0] rdData_b, rdData_n;
    logic        busy_b, busy_n, drop_b, drop_n;

    int total = 0;
    int bad   = 0;
    int busy_cnt;

    reg_file_mp #(.BYPASS(1)) u_dut_b (
        .clk(clk), .rst(rst), .rdAddr(rdAddr), .rdData(rdData_b),
        .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
        .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
        .clrReq(clrReq), .busy(busy_b), .wrDropped(drop_b)
    );

    reg_file_mp #(.BYPASS(0)) u_dut_n (
        .clk(clk), .rst(rst), .rdAddr(rdAddr), .rdData(rdData_n),
        .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
        .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
        .clrReq(clrReq), .busy(busy_n), .wrDropped(drop_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int a0, input int a1);
        rdAddr = {5'(a1), 5'(a0)};
    endtask

    task automatic idle_inputs();
        wrEn0 = 1'b0; wrEn1 = 1'b0; clrReq = 1'b0;
        wrAddr0 = '0; wrAddr1 = '0; wrData0 = '0; wrData1 = '0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        set_rd(0, 0);
        repeat (2) @(negedge clk);
        chk("reset_busy", {62'd0, busy_b, busy_n}, 64'd0);
        chk("reset_drop", {62'd0, drop_b, drop_n}, 64'd0);
        rst = 1'b1;

        // every entry reads zero after reset
        for (int i = 0; i < 32; i++) begin
            set_rd(i, 31 - i);
            #1;
            chk("reset_read_b", rdData_b, 64'd0);
            chk("reset_read_n", rdData_n, 64'd0);
        end

        // single write with and without bypass
        @(negedge clk);
        wrEn0 = 1'b1; wrAddr0 = 5'd5; wrData0 = 32'hDEADBEEF;
        set_rd(5, 0);
        #1;
        chk("bypass_r5", {32'd0, rdData_b[31:0]}, 64'h0000_0000_DEAD_BEEF);
        chk("nobypass_r5_old", {32'd0, rdData_n[31:0]}, 64'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("nobypass_r5_new", {32'd0, rdData_n[31:0]}, 64'h0000_0000_DEAD_BEEF);
        chk("stored_r5", {32'd0, rdData_b[31:0]}, 64'h0000_0000_DEAD_BEEF);

        // port-0 bypass works alone, port 1 wins a same-address collision
        @(negedge clk);
        wrEn0 = 1'b1; wrAddr0 = 5'd7; wrData0 = 32'h11111111;
        wrEn1 = 1'b1; wrAddr1 = 5'd7; wrData1 = 32'h22222222;
        set_rd(5, 7);
        #1;
        chk("collide_bypass_r7", {32'd0, rdData_b[63:32]}, 64'h0000_0000_2222_2222);
        chk("collide_r5_kept", {32'd0, rdData_b[31:0]}, 64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("collide_r7_b", {32'd0, rdData_b[63:32]}, 64'h0000_0000_2222_2222);
        chk("collide_r7_n", {32'd0, rdData_n[63:32]}, 64'h0000_0000_2222_2222);

        // writes to r0 are discarded and r0 always reads zero
        @(negedge clk);
        wrEn0 = 1'b1; wrAddr0 = 5'd0; wrData0 = 32'hFFFFFFFF;
        wrEn1 = 1'b1; wrAddr1 = 5'd0; wrData1 = 32'hFFFFFFFF;
        set_rd(0, 0);
        #1;
        chk("r0_bypass", rdData_b, 64'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("r0_after_b", rdData_b, 64'd0);
        chk("r0_after_n", rdData_n, 64'd0);

        // preload r1..r31 with their index
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            wrEn0 = 1'b1; wrAddr0 = 5'(i); wrData0 = 32'(i);
        end
        @(negedge clk);
        idle_inputs();
        set_rd(1, 31);
        #1;
        chk("preload_r1_r31", rdData_b, {32'd31, 32'd1});

        // one-cycle clear request
        @(negedge clk);
        clrReq = 1'b1;
        #1;
        chk("busy_before_accept", {63'd0, busy_b}, 64'd0);
        busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            clrReq = 1'b0;
            wrEn0  = 1'b0;
            #1;
            if (busy_b) busy_cnt++;
            if (c == 3) begin
                set_rd(1, 31);
                #1;
                chk("clear3_r1_r31", rdData_b, {32'd31, 32'd0});
                chk("clear3_drop", {63'd0, drop_b}, 64'd0);
                wrEn0 = 1'b1; wrAddr0 = 5'd9; wrData0 = 32'h0000ABCD;
                set_rd(9, 9);
                #1;
                chk("clear3_no_bypass_r9", rdData_b, {32'd9, 32'd9});
            end
            if (c == 4) begin
                chk("clear4_drop_pulse", {62'd0, drop_b, drop_n}, 64'd3);
                chk("clear4_r9_old", {32'd0, rdData_b[31:0]}, 64'd9);
            end
            if (c == 5) begin
                chk("clear5_drop_low", {63'd0, drop_b}, 64'd0);
                clrReq = 1'b1;
            end
        end
        chk("busy_cycles", 64'(busy_cnt), 64'd32);
        chk("busy_after_clear", {62'd0, busy_b, busy_n}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            set_rd(i, i);
            #1;
            chk("post_clear_b", rdData_b, 64'd0);
            chk("post_clear_n", rdData_n, 64'd0);
        end

        // reset in the middle of a clear
        @(negedge clk);
        wrEn0 = 1'b1; wrAddr0 = 5'd20; wrData0 = 32'd20;
        @(negedge clk);
        idle_inputs();
        clrReq = 1'b1;
        @(negedge clk);
        clrReq = 1'b0;
        repeat (9) @(negedge clk);
        set_rd(20, 20);
        #1;
        chk("midclear_r20_before", rdData_b, {32'd20, 32'd20});
        #1;
        rst = 1'b0;
        #1;
        chk("abort_busy", {62'd0, busy_b, busy_n}, 64'd0);
        chk("abort_drop", {62'd0, drop_b, drop_n}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            set_rd(i, i);
            #1;
            chk("abort_zero", rdData_b, 64'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wrEn0 = 1'b1; wrAddr0 = 5'd3; wrData0 = 32'h0000005A;
        set_rd(3, 3);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("post_abort_r3_b", rdData_b, {32'h5A, 32'h5A});
        chk("post_abort_r3_n", rdData_n, {32'h5A, 32'h5A});
        chk("post_abort_busy", {62'd0, busy_b, busy_n}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
